// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB arbiter with address/control and write-data multiplexing
//
// Shares one AHB address/data path among MST_NUM masters. The grant moves only
// at transfer boundaries: the owner is idle, or it has just had the last beat
// of a fixed-length burst accepted, and never while the owner holds its lock.
//
// Ports:
//   hclk, hresetn        clock, asynchronous active-low reset
//   m_hbusreq            per-master bus request
//   m_haddr .. m_hwdata  packed per-master AHB master outputs (master i at slice i)
//   hready, hresp        shared ready/response from the interconnect
//   m_hgrant             registered one-hot grant
//   haddr .. hmasterlock address/control of the granted (address-phase) master
//   hwdata               write data of the data-phase owner
//   hmaster              zero-extended index of the address-phase owner
module ahb_arbiter #(
  parameter int MST_NUM       = 4,
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int HBURST_WIDTH  = 3,
  parameter int HMASTER_WIDTH = 8
) (
  input  logic                            hclk,
  input  logic                            hresetn,
  input  logic [MST_NUM-1:0]              m_hbusreq,
  input  logic [MST_NUM*ADDR_WIDTH-1:0]   m_haddr,
  input  logic [MST_NUM*2-1:0]            m_htrans,
  input  logic [MST_NUM-1:0]              m_hwrite,
  input  logic [MST_NUM*3-1:0]            m_hsize,
  input  logic [MST_NUM*HBURST_WIDTH-1:0] m_hburst,
  input  logic [MST_NUM-1:0]              m_hmasterlock,
  input  logic [MST_NUM*DATA_WIDTH-1:0]   m_hwdata,
  input  logic                            hready,
  input  logic                            hresp,
  output logic [MST_NUM-1:0]              m_hgrant,
  output logic [ADDR_WIDTH-1:0]           haddr,
  output logic [1:0]                      htrans,
  output logic                            hwrite,
  output logic [2:0]                      hsize,
  output logic [HBURST_WIDTH-1:0]         hburst,
  output logic                            hmasterlock,
  output logic [DATA_WIDTH-1:0]           hwdata,
  output logic [HMASTER_WIDTH-1:0]        hmaster
);

  localparam int OWN_W = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [ADDR_WIDTH-1:0]   addr_a  [MST_NUM];
  logic [1:0]              trans_a [MST_NUM];
  logic [2:0]              size_a  [MST_NUM];
  logic [HBURST_WIDTH-1:0] burst_a [MST_NUM];
  logic [DATA_WIDTH-1:0]   wdata_a [MST_NUM];

  genvar g;
  for (g = 0; g < MST_NUM; g++) begin : g_split
    assign addr_a[g]  = m_haddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign trans_a[g] = m_htrans[g*2 +: 2];
    assign size_a[g]  = m_hsize[g*3 +: 3];
    assign burst_a[g] = m_hburst[g*HBURST_WIDTH +: HBURST_WIDTH];
    assign wdata_a[g] = m_hwdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [OWN_W-1:0] own_q;
  logic [OWN_W-1:0] down_q;
  logic [4:0]       beat_q;

  logic [4:0]       beat_nxt;
  logic [4:0]       burst_len;
  logic             burst_end;
  logic             arb_point;
  logic [OWN_W-1:0] next_own;
  logic             found;
  logic [OWN_W:0]   cand_sum;

  assign haddr       = addr_a[own_q];
  assign htrans      = trans_a[own_q];
  assign hwrite      = m_hwrite[own_q];
  assign hsize       = size_a[own_q];
  assign hburst      = burst_a[own_q];
  assign hmasterlock = m_hmasterlock[own_q];
  assign hwdata      = wdata_a[down_q];
  assign hmaster     = HMASTER_WIDTH'(own_q);

  // Error handling is the master's job: it answers ERROR with IDLE, which is
  // itself an arbitration point, so the response is never looked at here.
  logic unused_hresp;
  assign unused_hresp = hresp;

  always_comb begin
    beat_nxt  = beat_q;
    burst_len = 5'd0;
    case (htrans)
      HTRANS_IDLE:   beat_nxt = 5'd0;
      HTRANS_BUSY:   beat_nxt = beat_q;
      HTRANS_NONSEQ: beat_nxt = 5'd1;
      default:       beat_nxt = beat_q + 5'd1;
    endcase
    // Zero means no fixed end point (undefined-length INCR).
    case (hburst)
      3'b000:         burst_len = 5'd1;
      3'b010, 3'b011: burst_len = 5'd4;
      3'b100, 3'b101: burst_len = 5'd8;
      3'b110, 3'b111: burst_len = 5'd16;
      default:        burst_len = 5'd0;
    endcase
    burst_end = htrans[1] && (burst_len != 5'd0) && (beat_nxt == burst_len);
    arb_point = hready && !hmasterlock && ((htrans == HTRANS_IDLE) || burst_end);
  end

  // Round-robin search starting just after the owner; the owner is checked
  // last so a continuously requesting owner cannot starve the others.
  always_comb begin
    next_own = own_q;
    found    = 1'b0;
    cand_sum = '0;
    for (int i = 1; i <= MST_NUM; i++) begin
      cand_sum = {1'b0, own_q} + (OWN_W+1)'(i);
      if (cand_sum >= (OWN_W+1)'(MST_NUM)) begin
        cand_sum = cand_sum - (OWN_W+1)'(MST_NUM);
      end
      if (!found && m_hbusreq[cand_sum[OWN_W-1:0]]) begin
        found    = 1'b1;
        next_own = cand_sum[OWN_W-1:0];
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      own_q    <= '0;
      down_q   <= '0;
      beat_q   <= 5'd0;
      m_hgrant <= MST_NUM'(1);
    end else if (hready) begin
      down_q <= own_q;
      beat_q <= beat_nxt;
      if (arb_point) begin
        own_q    <= next_own;
        m_hgrant <= MST_NUM'(1) << next_own;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed self-checking bench for ahb_arbiter
module tb_ahb_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 3;
  localparam int HW = 8;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] WRAP4  = 3'b010;
  localparam logic [2:0] INCR4  = 3'b011;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic [N-1:0]    m_hbusreq;
  logic [N*AW-1:0] m_haddr;
  logic [N*2-1:0]  m_htrans;
  logic [N-1:0]    m_hwrite;
  logic [N*3-1:0]  m_hsize;
  logic [N*BW-1:0] m_hburst;
  logic [N-1:0]    m_hmasterlock;
  logic [N*DW-1:0] m_hwdata;
  logic            hready;
  logic            hresp;
  logic [N-1:0]    m_hgrant;
  logic [AW-1:0]   haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [BW-1:0]   hburst;
  logic            hmasterlock;
  logic [DW-1:0]   hwdata;
  logic [HW-1:0]   hmaster;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_arbiter #(
    .MST_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HBURST_WIDTH(BW), .HMASTER_WIDTH(HW)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .m_hbusreq(m_hbusreq), .m_haddr(m_haddr),
    .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
    .m_hmasterlock(m_hmasterlock), .m_hwdata(m_hwdata), .hready(hready), .hresp(hresp),
    .m_hgrant(m_hgrant), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hmasterlock(hmasterlock), .hwdata(hwdata), .hmaster(hmaster)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input int m, input logic [1:0] t, input logic [2:0] b, input logic lk);
    m_htrans[m*2 +: 2]   = t;
    m_hburst[m*BW +: BW] = b;
    m_hmasterlock[m]     = lk;
  endtask

  task automatic idle_all();
    for (int m = 0; m < N; m++) drive(m, IDLE, SINGLE, 1'b0);
    m_hbusreq = '0;
  endtask

  task automatic test_reset();
    hresetn  = 1'b0;
    m_haddr  = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    m_hwdata = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    m_hwrite = 4'b1010;
    m_hsize  = {3'd3, 3'd2, 3'd1, 3'd2};
    hready   = 1'b1;
    hresp    = 1'b0;
    idle_all();
    #12;
    n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL reset_grant: got %b expected 0001", m_hgrant); end
    n_checks++; if (hmaster !== 8'd0) begin n_fail++; $display("FAIL reset_hmaster: got %0d expected 0", hmaster); end
    n_checks++; if (haddr !== 16'h1000) begin n_fail++; $display("FAIL reset_haddr: got %h expected 1000", haddr); end
    n_checks++; if (htrans !== IDLE) begin n_fail++; $display("FAIL reset_htrans: got %b expected 00", htrans); end
    n_checks++; if (hsize !== 3'd2) begin n_fail++; $display("FAIL reset_hsize: got %0d expected 2", hsize); end
    n_checks++; if (hwdata !== 32'hD000_0000) begin n_fail++; $display("FAIL reset_hwdata: got %h expected d0000000", hwdata); end
    n_checks++; if (dut.beat_q !== 5'd0) begin n_fail++; $display("FAIL reset_beat: got %0d expected 0", dut.beat_q); end
    tick();
    hresetn = 1'b1;
    tick();
    n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL park_idle: got %b expected 0001", m_hgrant); end
  endtask

  task automatic test_incr4_handover();
    m_hbusreq = 4'b0011;
    drive(0, NONSEQ, INCR4, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL incr4_hold beat %0d: got %b expected 0001", k, m_hgrant); end
      n_checks++; if (dut.beat_q !== 5'(k)) begin n_fail++; $display("FAIL incr4_beat: got %0d expected %0d", dut.beat_q, k); end
      drive(0, SEQ, INCR4, 1'b0);
    end
    n_checks++; if (hwdata !== 32'hD000_0000) begin n_fail++; $display("FAIL incr4_wdata_m0: got %h expected d0000000", hwdata); end
    tick();
    n_checks++; if (m_hgrant !== 4'b0010) begin n_fail++; $display("FAIL incr4_switch: got %b expected 0010", m_hgrant); end
    n_checks++; if (hmaster !== 8'd1) begin n_fail++; $display("FAIL incr4_hmaster: got %0d expected 1", hmaster); end
    n_checks++; if (haddr !== 16'h2000) begin n_fail++; $display("FAIL incr4_haddr: got %h expected 2000", haddr); end
    n_checks++; if (hwdata !== 32'hD000_0000) begin n_fail++; $display("FAIL incr4_wdata_last: got %h expected d0000000", hwdata); end
    drive(0, IDLE, SINGLE, 1'b0);
    m_hbusreq = 4'b0010;
    tick();
    n_checks++; if (hwdata !== 32'hD000_0001) begin n_fail++; $display("FAIL incr4_wdata_m1: got %h expected d0000001", hwdata); end
    n_checks++; if (m_hgrant !== 4'b0010) begin n_fail++; $display("FAIL incr4_keep: got %b expected 0010", m_hgrant); end
    m_hbusreq = '0;
  endtask

  task automatic test_round_robin();
    int exp_own[4];
    int prev;
    exp_own = '{2, 3, 0, 1};
    prev = 1;
    m_hbusreq = 4'b1111;
    for (int m = 0; m < N; m++) drive(m, NONSEQ, SINGLE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (m_hgrant !== 4'(1 << exp_own[k])) begin n_fail++; $display("FAIL rr_grant step %0d: got %b expected %b", k, m_hgrant, 4'(1 << exp_own[k])); end
      n_checks++; if (hmaster !== 8'(exp_own[k])) begin n_fail++; $display("FAIL rr_hmaster step %0d: got %0d expected %0d", k, hmaster, exp_own[k]); end
      n_checks++; if (hwdata !== 32'hD000_0000 + 32'(prev)) begin n_fail++; $display("FAIL rr_wdata step %0d: got %h expected %h", k, hwdata, 32'hD000_0000 + 32'(prev)); end
      prev = exp_own[k];
    end
    idle_all();
    tick();
    n_checks++; if (m_hgrant !== 4'b0010) begin n_fail++; $display("FAIL rr_park: got %b expected 0010", m_hgrant); end
  endtask

  task automatic test_lock();
    m_hbusreq = 4'b0100;
    tick();
    n_checks++; if (m_hgrant !== 4'b0100) begin n_fail++; $display("FAIL lock_take: got %b expected 0100", m_hgrant); end
    drive(2, NONSEQ, SINGLE, 1'b1);
    m_hbusreq = 4'b1100;
    tick();
    n_checks++; if (m_hgrant !== 4'b0100) begin n_fail++; $display("FAIL lock_hold_xfer: got %b expected 0100", m_hgrant); end
    drive(2, IDLE, SINGLE, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (m_hgrant !== 4'b0100) begin n_fail++; $display("FAIL lock_hold_idle %0d: got %b expected 0100", k, m_hgrant); end
    end
    drive(2, IDLE, SINGLE, 1'b0);
    m_hbusreq = 4'b1000;
    tick();
    n_checks++; if (m_hgrant !== 4'b1000) begin n_fail++; $display("FAIL lock_release: got %b expected 1000", m_hgrant); end
    n_checks++; if (hmaster !== 8'd3) begin n_fail++; $display("FAIL lock_hmaster: got %0d expected 3", hmaster); end
  endtask

  task automatic test_wait_states();
    m_hbusreq = 4'b1001;
    drive(3, NONSEQ, INCR4, 1'b0);
    tick();
    drive(3, SEQ, INCR4, 1'b0);
    hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (m_hgrant !== 4'b1000) begin n_fail++; $display("FAIL wait_grant %0d: got %b expected 1000", k, m_hgrant); end
      n_checks++; if (dut.beat_q !== 5'd1) begin n_fail++; $display("FAIL wait_beat %0d: got %0d expected 1", k, dut.beat_q); end
    end
    hready = 1'b1;
    tick();
    n_checks++; if (dut.beat_q !== 5'd2) begin n_fail++; $display("FAIL wait_beat2: got %0d expected 2", dut.beat_q); end
    tick();
    n_checks++; if (m_hgrant !== 4'b1000) begin n_fail++; $display("FAIL wait_beat3_grant: got %b expected 1000", m_hgrant); end
    hready = 1'b0;
    tick();
    n_checks++; if (m_hgrant !== 4'b1000) begin n_fail++; $display("FAIL wait_last_beat: got %b expected 1000", m_hgrant); end
    hready = 1'b1;
    tick();
    n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL wait_switch: got %b expected 0001", m_hgrant); end
    n_checks++; if (hwdata !== 32'hD000_0003) begin n_fail++; $display("FAIL wait_wdata_m3: got %h expected d0000003", hwdata); end
    drive(3, IDLE, SINGLE, 1'b0);
    m_hbusreq = 4'b0001;
    hready = 1'b0;
    tick();
    n_checks++; if (hwdata !== 32'hD000_0003) begin n_fail++; $display("FAIL wait_wdata_frozen: got %h expected d0000003", hwdata); end
    hready = 1'b1;
    tick();
    n_checks++; if (hwdata !== 32'hD000_0000) begin n_fail++; $display("FAIL wait_wdata_m0: got %h expected d0000000", hwdata); end
  endtask

  task automatic test_error();
    m_hbusreq = 4'b0011;
    drive(0, NONSEQ, WRAP4, 1'b0);
    tick();
    drive(0, SEQ, WRAP4, 1'b0);
    hresp = 1'b1;
    tick();
    n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL err_hold: got %b expected 0001", m_hgrant); end
    n_checks++; if (dut.beat_q !== 5'd2) begin n_fail++; $display("FAIL err_beat2: got %0d expected 2", dut.beat_q); end
    drive(0, IDLE, WRAP4, 1'b0);
    tick();
    hresp = 1'b0;
    n_checks++; if (m_hgrant !== 4'b0010) begin n_fail++; $display("FAIL err_regrant: got %b expected 0010", m_hgrant); end
    n_checks++; if (dut.beat_q !== 5'd0) begin n_fail++; $display("FAIL err_beat_clear: got %0d expected 0", dut.beat_q); end
    idle_all();
  endtask

  task automatic test_reset_mid_burst();
    m_hbusreq = 4'b0010;
    drive(1, NONSEQ, INCR4, 1'b0);
    tick();
    drive(1, SEQ, INCR4, 1'b0);
    #2;
    hresetn = 1'b0;
    #1;
    n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 0001", m_hgrant); end
    n_checks++; if (hmaster !== 8'd0) begin n_fail++; $display("FAIL rst_mid_hmaster: got %0d expected 0", hmaster); end
    n_checks++; if (dut.beat_q !== 5'd0) begin n_fail++; $display("FAIL rst_mid_beat: got %0d expected 0", dut.beat_q); end
    idle_all();
    tick();
    hresetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_incr4_handover();
    test_round_robin();
    test_lock();
    test_wait_states();
    test_error();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter and address/data multiplexer that lets up to MST_NUM `ahb_master`-style requesters share one AHB address/data path toward the interconnect. The block collects per-master bus requests and issues a one-hot grant, moving it only at legal transfer boundaries (idle, end of fixed-length burst, never inside a locked sequence). It routes the granted master's address/control to the shared bus, routes the data-phase owner's write data, and drives `hmaster` with the owner index.

## Interface
Parameters:
- MST_NUM, 4, number of requesting masters (2–8)
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 32, data width
- HBURST_WIDTH, 3, burst field width
- HMASTER_WIDTH, 8, `hmaster` width (owner index zero-extended)

Ports:
- hclk  in  1  bus clock
- hresetn  in  1  reset, asynchronous, active-low
- m_hbusreq  in  MST_NUM  bus request per master
- m_haddr  in  MST_NUM*ADDR_WIDTH  packed per-master address, master i at slice i
- m_htrans  in  MST_NUM*2  packed per-master HTRANS
- m_hwrite  in  MST_NUM  per-master HWRITE
- m_hsize  in  MST_NUM*3  per-master HSIZE
- m_hburst  in  MST_NUM*HBURST_WIDTH  per-master HBURST
- m_hmasterlock  in  MST_NUM  per-master lock
- m_hwdata  in  MST_NUM*DATA_WIDTH  per-master write data
- hready  in  1  shared bus ready from interconnect
- hresp  in  1  shared response (1 = ERROR)
- m_hgrant  out  MST_NUM  one-hot grant (registered)
- haddr, htrans, hwrite, hsize, hburst, hmasterlock  out  matching widths  address/control of granted master
- hwdata  out  DATA_WIDTH  write data of data-phase owner
- hmaster  out  HMASTER_WIDTH  index of address-phase owner

## Operation
- State: `own_q` (owner index), `m_hgrant` = onehot(`own_q`), `down_q` (data-phase owner index), `beat_q` (beats accepted in current burst, 5 bits).
- Address mux: all address/control outputs = slice `own_q` of master inputs; `hmaster` = `own_q`. Non-granted masters are invisible to the bus.
- Data mux: `hwdata` = slice `down_q`. `down_q` <= `own_q` on every edge with `hready`=1.
- Beat counter, on `hready`=1: NONSEQ -> `beat_q`=1; SEQ -> `beat_q`+1; IDLE -> 0; BUSY -> hold.
- Burst length: SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, INCR=undefined (no end-of-burst point).
- Arbitration point (all required): `hready`=1, owner `m_hmasterlock`=0, and one of: owner htrans=IDLE; owner htrans∈{NONSEQ,SEQ} and this beat completes the fixed-length burst (count after increment = length).
- At an arbitration point: search `m_hbusreq` round-robin from `own_q`+1 mod MST_NUM, wrapping, owner checked last. First requester found becomes owner. If none requests, owner parks (unchanged).
- Owner keeping its request through an arbitration point is rearbitrated fairly; it keeps the bus only if no other master requests.
- ERROR: arbiter does not act on `hresp` directly. A master receiving ERROR drives IDLE, creating an arbitration point. `beat_q` clears on that IDLE.
- Locked owner holds the grant through IDLE cycles until its lock drops.
- Masters qualify `hready` with their own `m_hgrant`. A newly granted master drives NONSEQ or IDLE in its first granted cycle.

## Timing
- Reset (async, `hresetn`=0): `own_q`=0, `down_q`=0, `beat_q`=0, `m_hgrant`=…0001, `hmaster`=0. Muxed outputs follow master 0 combinationally.
- Grant latency: request sampled at arbitration-point edge -> `m_hgrant` and address mux switch the next cycle (1 clock). Minimum idle-bus request-to-NONSEQ is 1 cycle after the edge.
- `hready`=0 freezes `own_q`, `down_q`, `beat_q`. No grant change while a wait state is pending.
- `hwdata` switches to the new owner one `hready` edge after the address owner switches (pipelined data phase).
- Simultaneous requests: resolved purely by round-robin order, never fixed priority.
- Reset mid-burst: immediate return to master 0 grant. No transfer completion is guaranteed.

## Test plan
- Reset, no requests -> `m_hgrant`=4'b0001, `hmaster`=0. Master0 htrans=IDLE passes to bus.
- Owner 0 issues INCR4 (NONSEQ + 3 SEQ, `hready`=1) while m1 requests -> grant stays 0001 for 4 beats, becomes 0010 the cycle after beat 4. `hwdata` from m0 through data phase of beat 4, then m1.
- All four request continuously, SINGLE transfers -> grants rotate 0→1→2→3→0, one per transfer.
- m2 locked (hmasterlock=1) with IDLE gaps, m3 requesting -> grant held at 0100 until lock drops, then 1000 next cycle.
- INCR4 beat 2 with `hready` low 3 cycles -> `beat_q`, grant, `down_q` frozen. Burst ends after 4 accepted beats.
- ERROR on beat 2 of WRAP4, owner drives IDLE -> arbitration at that IDLE, `beat_q`=0, next requester granted.
